// File: rtl/ar_rr_arbiter.sv
// Round-robin arbiter sharing one registered AR channel among NUM_REQ requesters,
// with a per-source outstanding-read limit tracked through a completion port.
module ar_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned MAX_OUT    = 8,
  localparam int unsigned SRC_W     = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(MAX_OUT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]     req_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*3-1:0]            req_size,
  input  logic [NUM_REQ*2-1:0]            req_burst,
  input  logic [NUM_REQ*4-1:0]            req_qos,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tagid,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [ID_WIDTH-1:0]             m_id,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [LEN_WIDTH-1:0]            m_len,
  output logic [2:0]                      m_size,
  output logic [1:0]                      m_burst,
  output logic [3:0]                      m_qos,
  output logic [TAG_WIDTH-1:0]            m_tagid,
  output logic [SRC_W-1:0]                m_src,
  input  logic                            done_valid,
  input  logic [SRC_W-1:0]                done_src,
  output logic                            busy,
  output logic                            err_underflow
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
    logic [TAG_WIDTH-1:0]  tagid;
  } ar_t;

  logic               m_valid_q, m_valid_d;
  ar_t                ar_q, ar_d, sel_ar;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] eligible, hi_elig, pick;
  logic [SRC_W-1:0]   win;
  logic               found, can_load, grant, cnt_nz;

  // Eligibility uses the registered counters, so a same-cycle done cannot unblock.
  always_comb begin
    eligible = '0;
    hi_elig  = '0;
    cnt_nz   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
      hi_elig[i]  = eligible[i] && (SRC_W'(i) >= ptr_q);
      cnt_nz      = cnt_nz | (cnt_q[i] != '0);
    end
  end

  // Rotating priority: lowest eligible index at or above ptr, else lowest overall.
  always_comb begin
    pick  = (|hi_elig) ? hi_elig : eligible;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        found = 1'b1;
        win   = SRC_W'(i);
      end
    end
  end

  assign can_load = ~m_valid_q | m_ready;
  assign grant    = can_load & (|eligible);

  always_comb begin
    req_ready = '0;
    sel_ar    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win == SRC_W'(i));
      if (win == SRC_W'(i)) begin
        sel_ar.id    = req_id[i*ID_WIDTH +: ID_WIDTH];
        sel_ar.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_ar.len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        sel_ar.size  = req_size[i*3 +: 3];
        sel_ar.burst = req_burst[i*2 +: 2];
        sel_ar.qos   = req_qos[i*4 +: 4];
        sel_ar.tagid = req_tagid[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Next-state: output register, pointer, outstanding counters, sticky error.
  always_comb begin
    logic inc;
    logic dec;
    m_valid_d = m_valid_q;
    ar_d      = ar_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    inc       = 1'b0;
    dec       = 1'b0;
    if (grant) begin
      m_valid_d = 1'b1;
      ar_d      = sel_ar;
      src_d     = win;
      ptr_d     = (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    if (done_valid && (32'(done_src) >= NUM_REQ)) err_d = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      inc = grant && (win == SRC_W'(i));
      dec = done_valid && (done_src == SRC_W'(i));
      if (dec && (cnt_q[i] == '0)) err_d = 1'b1;
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      ar_q      <= '0;
      src_q     <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      ar_q      <= ar_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_id          = ar_q.id;
  assign m_addr        = ar_q.addr;
  assign m_len         = ar_q.len;
  assign m_size        = ar_q.size;
  assign m_burst       = ar_q.burst;
  assign m_qos         = ar_q.qos;
  assign m_tagid       = ar_q.tagid;
  assign m_src         = src_q;
  assign busy          = m_valid_q | cnt_nz;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Bench for ar_rr_arbiter: directed scenarios plus random traffic against an
// integer-level model of grants, outstanding counts and the output register.
module tb_ar_rr_arbiter;
  localparam int MO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_id;
  logic [127:0] req_addr;
  logic [31:0] req_len;
  logic [11:0] req_size;
  logic [7:0]  req_burst;
  logic [15:0] req_qos, req_tagid;
  logic        m_valid, m_ready;
  logic [3:0]  m_id, m_qos, m_tagid;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst, m_src, done_src;
  logic        done_valid, busy, err_underflow;
  logic [56:0] obs;

  int checks = 0;
  int errors = 0;

  // Model state
  bit          mvalid;
  int          msrc, mptr;
  int          mcnt [4];
  bit          merr;
  logic [56:0] mbus;

  always #5 clk = ~clk;

  ar_rr_arbiter #(.NUM_REQ(4), .ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(8),
                  .TAG_WIDTH(4), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_burst(req_burst), .req_qos(req_qos), .req_tagid(req_tagid),
    .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_addr(m_addr),
    .m_len(m_len), .m_size(m_size), .m_burst(m_burst), .m_qos(m_qos),
    .m_tagid(m_tagid), .m_src(m_src), .done_valid(done_valid), .done_src(done_src),
    .busy(busy), .err_underflow(err_underflow));

  assign obs = {m_id, m_addr, m_len, m_size, m_burst, m_qos, m_tagid};

  function automatic logic [56:0] src_fields(int s);
    return {req_id[s*4 +: 4], req_addr[s*32 +: 32], req_len[s*8 +: 8], req_size[s*3 +: 3],
            req_burst[s*2 +: 2], req_qos[s*4 +: 4], req_tagid[s*4 +: 4]};
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (mptr + k) % 4;
      if (req_valid[s] && mcnt[s] < MO) return s;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int w;
    w = model_winner();
    if (w >= 0 && (!mvalid || m_ready)) return 4'(1 << w);
    return 4'd0;
  endfunction

  function automatic bit model_busy();
    bit b;
    b = mvalid;
    for (int i = 0; i < 4; i++) if (mcnt[i] > 0) b = 1'b1;
    return b;
  endfunction

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    int w, ds;
    bit g;
    logic [56:0] f;
    w = model_winner();
    g = (w >= 0) && (!mvalid || m_ready);
    f = (w >= 0) ? src_fields(w) : 57'd0;
    ds = int'(done_src);
    @(posedge clk);
    if (!rst) begin
      mvalid = 0; msrc = 0; mbus = '0; mptr = 0; merr = 0;
      for (int i = 0; i < 4; i++) mcnt[i] = 0;
    end else begin
      if (done_valid) begin
        if (ds >= 4) merr = 1;
        else begin
          if (mcnt[ds] == 0) merr = 1;
          if (mcnt[ds] > 0 || (g && ds == w)) mcnt[ds]--;
        end
      end
      if (g) begin
        mcnt[w]++;
        mvalid = 1; msrc = w; mbus = f; mptr = (w + 1) % 4;
      end else if (mvalid && m_ready) begin
        mvalid = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    req_valid = '0; m_ready = 1'b0; done_valid = 1'b0; done_src = '0;
  endtask

  task automatic rand_fields();
    req_id = 16'($urandom); req_addr = {$urandom, $urandom, $urandom, $urandom};
    req_len = $urandom; req_size = 12'($urandom); req_burst = 8'($urandom);
    req_qos = 16'($urandom); req_tagid = 16'($urandom);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rand_fields();
    do_reset();
    rst = 1'b0;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", m_src); end
    checks++; if (obs !== 57'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", obs); end
    checks++; if (busy !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b err=%b exp 0 0", busy, err_underflow); end
    checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    rst = 1'b1;
  endtask

  task automatic test_rotation();
    do_reset();
    req_valid = 4'hF; m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_fields();
      done_valid = mvalid; done_src = 2'(msrc);
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rot_ready c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4))); end
      tick();
      checks++; if (m_valid !== 1'b1 || m_src !== 2'(c % 4)) begin
        errors++; $display("FAIL rot_src c=%0d got v=%b src=%0d exp v=1 src=%0d", c, m_valid, m_src, c % 4); end
      checks++; if (obs !== mbus) begin errors++; $display("FAIL rot_fields c=%0d got %h exp %h", c, obs, mbus); end
    end
    req_valid = '0; done_valid = 1'b1; done_src = 2'(msrc);
    tick();
    done_valid = 1'b0;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rot_drain got v=%b busy=%b exp 0 0", m_valid, busy); end
  endtask

  task automatic test_stall();
    do_reset();
    rand_fields();
    req_addr[64 +: 32] = 32'h1000;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL stall_grant got %b exp 0100", req_ready); end
    tick();
    req_addr[64 +: 32] = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || m_addr !== 32'h1000 || m_src !== 2'd2) begin
        errors++; $display("FAIL stall_hold k=%0d got v=%b addr=%h src=%0d exp v=1 addr=1000 src=2",
                           k, m_valid, m_addr, m_src); end
      checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL stall_ready k=%0d got %b exp 0000", k, req_ready); end
      if (k < 2) tick();
    end
    m_ready = 1'b1; req_valid = '0;
    tick();
    checks++; if (m_valid !== 1'b0 || m_addr !== 32'h1000 || busy !== 1'b1) begin
      errors++; $display("FAIL stall_accept got v=%b addr=%h busy=%b exp v=0 addr=1000 busy=1", m_valid, m_addr, busy); end
    done_valid = 1'b1; done_src = 2'd2;
    tick();
    done_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done busy got %b exp 0", busy); end
  endtask

  task automatic test_limit();
    do_reset();
    m_ready = 1'b1; req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== ((k < MO) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL limit_ready k=%0d got %b exp %b", k, req_ready, (k < MO) ? 4'b0010 : 4'b0000); end
      tick();
    end
    done_valid = 1'b1; done_src = 2'd1;
    #1;
    checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL limit_same_cycle got %b exp 0000", req_ready); end
    tick();
    done_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL limit_unblock got %b exp 0010", req_ready); end
    tick();
    checks++; if (m_valid !== 1'b1 || m_src !== 2'd1) begin
      errors++; $display("FAIL limit_regrant got v=%b src=%0d exp v=1 src=1", m_valid, m_src); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    m_ready = 1'b1;
    req_valid = 4'b0001; tick();
    req_valid = 4'b1000; tick();
    req_valid = 4'b0001; done_valid = 1'b1; done_src = 2'd0; tick();
    done_src = 2'd3; tick();
    done_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL same_last_slot got %b exp 0001", req_ready); end
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL same_blocked got %b exp 0000", req_ready); end
    req_valid = '0; done_valid = 1'b1; done_src = 2'd0;
    for (int k = 0; k < MO; k++) tick();
    done_valid = 1'b0;
    checks++; if (busy !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL same_drain got busy=%b err=%b exp 0 0", busy, err_underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    done_valid = 1'b1; done_src = 2'd2;
    tick();
    done_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (err_underflow !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL underflow_sticky k=%0d got err=%b busy=%b exp 1 0", k, err_underflow, busy); end
      tick();
    end
    rst = 1'b0; tick(); rst = 1'b1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b exp 0", err_underflow); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    m_ready = 1'b0; req_valid = '0;
    checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got v=%b busy=%b exp 1 1", m_valid, busy); end
    rst = 1'b0; tick(); rst = 1'b1;
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || m_src !== 2'd0) begin
      errors++; $display("FAIL mid_cleared got v=%b busy=%b src=%0d exp 0 0 0", m_valid, busy, m_src); end
    req_valid = 4'b1010; m_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_ready got %b exp 0010", req_ready); end
    tick();
    checks++; if (m_src !== 2'd1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL mid_first_grant got src=%0d v=%b exp 1 1", m_src, m_valid); end
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_fields();
      req_valid = 4'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      s = int'($urandom_range(0, 3));
      done_src = 2'(s);
      done_valid = ($urandom_range(0, 1) == 1) && (mcnt[s] > 0 || $urandom_range(0, 60) == 0);
      #1;
      checks++; if (req_ready !== model_ready()) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, model_ready()); end
      tick();
      checks++; if ({m_valid, m_src, obs} !== {mvalid, 2'(msrc), mbus}) begin
        errors++; $display("FAIL rnd_out c=%0d got v=%b src=%0d f=%h exp v=%b src=%0d f=%h",
                           c, m_valid, m_src, obs, mvalid, msrc, mbus); end
      checks++; if (busy !== model_busy() || err_underflow !== merr) begin
        errors++; $display("FAIL rnd_flags c=%0d got busy=%b err=%b exp %b %b",
                           c, busy, err_underflow, model_busy(), merr); end
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    rand_fields();
    #2;
    test_reset();
    test_rotation();
    test_stall();
    test_limit();
    test_same_cycle();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
